traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Sequences the intersection through green, yellow and all-red phases for the N+S and E+W lane pairs.
- Drives the 8-bit WWSSEENN lane bus consumed by the light drivers.
- Takes the green duration (load_time) from the active mode generator (day or night). In night mode it uses the lane sensor requests to hold green on the current pair.
- Sits between the mode generators and the output light drivers.

Parameters:
- YELLOW_TIME, 4, yellow phase length in clock cycles (1..127).
- ALL_RED_TIME, 2, all-red clearance length in clock cycles (1..127).
- WALK_TIME, 10, pedestrian walk length in cycles (used only with PED_WALK_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- night_mode  input  1  1 = night rules (sensor-held green), 0 = day rules (fixed cycle).
- load_time  input  7  green duration in cycles from the active mode generator; 0 is treated as 1.
- ns_request  input  1  vehicle present on N or S approach (level).
- ew_request  input  1  vehicle present on E or W approach (level).
- lane_output  output  8  WWSSEENN; per light 11=green, 01=yellow, 00=red; 10 is never driven.
- phase  output  3  current state encoding (debug/monitor).
- timer  output  7  remaining cycles in current phase, minus one.

Behaviour:
- States and encodings: RED_B=0, NS_GREEN=1, NS_YELLOW=2, RED_A=3, EW_GREEN=4, EW_YELLOW=5. WALK=6 exists only with PED_WALK_EN.
- Reset (async, immediate):
  - phase=RED_B.
  - timer=ALL_RED_TIME-1.
  - lane_output=8'b00000000.
  - After rst deasserts, the first NS_GREEN is reached after ALL_RED_TIME clocks.
- Timer rules:
  - On entry to any state, timer loads duration-1. Durations are: green = max(load_time,1), sampled on the entry edge; yellow = YELLOW_TIME; red = ALL_RED_TIME.
  - Each clock, timer decrements while nonzero.
  - At timer==0 the state exits on the next edge, subject to the hold rule below.
  - timer never wraps below 0.
- Transitions: RED_B -> NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B.
- Hold rule, green states only, evaluated at timer==0:
  - Day (night_mode=0): always exit.
  - Night (night_mode=1): exit NS_GREEN only if ew_request=1; exit EW_GREEN only if ns_request=1. Otherwise stay with timer held at 0.
  - When the request rises, the exit happens on the next edge.
- night_mode is sampled only at the green-expiry decision. A change mid-yellow or mid-red has no effect until the next green expiry.
- Simultaneous requests in night mode: the opposing pair is always served. There is no starvation because every green has a minimum of load_time.
- lane_output per state:
  - NS_GREEN 00110011.
  - NS_YELLOW 00010001.
  - EW_GREEN 11001100.
  - EW_YELLOW 01000100.
  - RED_A/RED_B/WALK 00000000.
- All outputs are registered, with no combinational path from inputs to outputs.
- A load_time change mid-green has no effect on the running green.
- rst asserted mid-phase forces the RED_B reset values immediately, regardless of state.

Optional Feature:
- Macro: PED_WALK_EN.
- Enabled:
  - Adds input ped_request (1 bit) and output walk (1 bit, reset 0).
  - A rising ped_request sets a sticky ped_pending flag.
  - At the next yellow exit with ped_pending=1, the FSM enters WALK (lanes all red, walk=1, duration WALK_TIME) instead of RED_A/RED_B, and clears ped_pending.
  - WALK then proceeds to the green that RED_A or RED_B would have led to.
  - A request arriving during WALK sets ped_pending for the following cycle of phases.
- Disabled: no ped ports; WALK is unreachable; phase never equals 6.

Decomposition:
- Shared package traffic_pkg holds:
  - state enumeration constants (RED_B..WALK).
  - lane codes LANE_NS_GREEN=8'b00110011, LANE_EW_GREEN=8'b11001100, LANE_NS_YELLOW, LANE_EW_YELLOW, LANE_ALL_RED.
  - light codes GREEN=2'b11, YELLOW=2'b01, RED=2'b00.
- One sub-module, phase_timer: a 7-bit loadable down-counter with load, load_value and zero outputs, using the same clk/rst.

Test Plan:
- Reset release, day, load_time=5, YELLOW=4, RED=2 -> NS_GREEN at cycle 2 for 5 cycles (00110011), then 4 cycles 00010001, 2 cycles 00000000, then 11001100. Full period 22 cycles.
- Night, load_time=3, ew_request=0 -> NS_GREEN held indefinitely with timer=0. Raise ew_request at cycle 40 -> NS_YELLOW at cycle 41.
- load_time=0 in day mode -> each green lasts exactly 1 cycle; no other phase is skipped.
- Assert rst mid-EW_GREEN -> lane_output=00000000 and phase=0 without waiting for a clock edge; NS_GREEN follows 2 cycles after release.
- Toggle night_mode 0->1 during NS_YELLOW with no requests -> EW_GREEN completes one load_time, then holds under the night rule.
- PED_WALK_EN, pulse ped_request during NS_GREEN -> after NS_YELLOW, walk=1 and lanes all red for 10 cycles, then EW_GREEN; no WALK in the following cycle of phases.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encodings, light/lane codes and helpers for the traffic phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED_B     = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_A     = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [1:0] GREEN  = 2'b11;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b00;

  // Lane bus layout is WWSSEENN
  localparam logic [7:0] LANE_NS_GREEN  = {RED, GREEN, RED, GREEN};
  localparam logic [7:0] LANE_EW_GREEN  = {GREEN, RED, GREEN, RED};
  localparam logic [7:0] LANE_NS_YELLOW = {RED, YELLOW, RED, YELLOW};
  localparam logic [7:0] LANE_EW_YELLOW = {YELLOW, RED, YELLOW, RED};
  localparam logic [7:0] LANE_ALL_RED   = {RED, RED, RED, RED};

  function automatic logic [7:0] lane_code(input state_t s);
    case (s)
      NS_GREEN:  lane_code = LANE_NS_GREEN;
      NS_YELLOW: lane_code = LANE_NS_YELLOW;
      EW_GREEN:  lane_code = LANE_EW_GREEN;
      EW_YELLOW: lane_code = LANE_EW_YELLOW;
      default:   lane_code = LANE_ALL_RED;
    endcase
  endfunction

  // A zero green request still yields a one-cycle green
  function automatic logic [6:0] green_load(input logic [6:0] t);
    green_load = (t == 7'd0) ? 7'd0 : t - 7'd1;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// 7-bit loadable down-counter that saturates at zero; flags the last cycle of a phase.
module phase_timer #(
  parameter logic [6:0] RESET_VALUE = 7'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [6:0] i_load_value,
  output logic [6:0] o_count,
  output logic       o_zero
);

  logic [6:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != 7'd0) begin
      r_count <= r_count - 7'd1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == 7'd0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Green/yellow/all-red sequencer for the N+S and E+W pairs with night-mode green hold.
// Optional pedestrian walk phase is built when PED_WALK_EN is defined.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       night_mode,
  input  logic [6:0] load_time,
  input  logic       ns_request,
  input  logic       ew_request,
`ifdef PED_WALK_EN
  input  logic       ped_request,
  output logic       walk,
`endif
  output logic [7:0] lane_output,
  output logic [2:0] phase,
  output logic [6:0] timer
);

  localparam logic [6:0] YELLOW_LOAD = 7'(YELLOW_TIME - 1);
  localparam logic [6:0] RED_LOAD    = 7'(ALL_RED_TIME - 1);
  localparam logic [6:0] WALK_LOAD   = 7'(WALK_TIME - 1);

  state_t     r_state;
  logic [7:0] r_lane;
  state_t     w_next_state;
  logic [6:0] w_load_value;
  logic       w_advance;
  logic       w_timer_zero;
  logic       w_walk_go;

`ifdef PED_WALK_EN
  logic r_walk;
  logic r_ped_prev;
  logic r_ped_pending;
  logic r_walk_to_ew;

  assign w_walk_go = r_ped_pending;
  assign walk      = r_walk;
`else
  assign w_walk_go = 1'b0;
`endif

  always_comb begin
    w_advance    = 1'b0;
    w_next_state = r_state;
    w_load_value = RED_LOAD;
    if (w_timer_zero) begin
      case (r_state)
        NS_GREEN: w_advance = !night_mode || ew_request;
        EW_GREEN: w_advance = !night_mode || ns_request;
        default:  w_advance = 1'b1;
      endcase
    end
    if (w_advance) begin
      case (r_state)
        RED_B:     w_next_state = NS_GREEN;
        NS_GREEN:  w_next_state = NS_YELLOW;
        NS_YELLOW: w_next_state = w_walk_go ? WALK : RED_A;
        RED_A:     w_next_state = EW_GREEN;
        EW_GREEN:  w_next_state = EW_YELLOW;
        EW_YELLOW: w_next_state = w_walk_go ? WALK : RED_B;
`ifdef PED_WALK_EN
        WALK:      w_next_state = r_walk_to_ew ? EW_GREEN : NS_GREEN;
`endif
        default:   w_next_state = RED_B;
      endcase
    end
    case (w_next_state)
      NS_GREEN, EW_GREEN:   w_load_value = green_load(load_time);
      NS_YELLOW, EW_YELLOW: w_load_value = YELLOW_LOAD;
      WALK:                 w_load_value = WALK_LOAD;
      default:              w_load_value = RED_LOAD;
    endcase
  end

  phase_timer #(
    .RESET_VALUE (RED_LOAD)
  ) u_phase_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_advance),
    .i_load_value (w_load_value),
    .o_count      (timer),
    .o_zero       (w_timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RED_B;
      r_lane        <= LANE_ALL_RED;
`ifdef PED_WALK_EN
      r_walk        <= 1'b0;
      r_ped_prev    <= 1'b0;
      r_ped_pending <= 1'b0;
      r_walk_to_ew  <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_lane  <= lane_code(w_next_state);
`ifdef PED_WALK_EN
      r_walk     <= (w_next_state == WALK);
      r_ped_prev <= ped_request;
      if (w_advance && w_next_state == WALK) begin
        r_ped_pending <= 1'b0;
        r_walk_to_ew  <= (r_state == NS_YELLOW);
      end
      // A fresh request wins over the clear so it is served on the next cycle of phases
      if (ped_request && !r_ped_prev) begin
        r_ped_pending <= 1'b1;
      end
`endif
    end
  end

  assign lane_output = r_lane;
  assign phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler; expected per-cycle phase/lane/timer queued ahead of time.
// Define PED_WALK_EN to also exercise the walk phase.
module tb_traffic_phase_scheduler;

  localparam logic [7:0] L_NSG = 8'b00110011;
  localparam logic [7:0] L_NSY = 8'b00010001;
  localparam logic [7:0] L_EWG = 8'b11001100;
  localparam logic [7:0] L_EWY = 8'b01000100;
  localparam logic [7:0] L_RED = 8'b00000000;

  typedef struct {
    logic [2:0] ph;
    logic [7:0] lane;
    logic [6:0] tm;
    logic       wk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       night_mode;
  logic [6:0] load_time;
  logic       ns_request;
  logic       ew_request;
  logic [7:0] lane_output;
  logic [2:0] phase;
  logic [6:0] timer;
`ifdef PED_WALK_EN
  logic       ped_request;
  logic       walk;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  traffic_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .night_mode  (night_mode),
    .load_time   (load_time),
    .ns_request  (ns_request),
    .ew_request  (ew_request),
`ifdef PED_WALK_EN
    .ped_request (ped_request),
    .walk        (walk),
`endif
    .lane_output (lane_output),
    .phase       (phase),
    .timer       (timer)
  );

  always #5 clk = ~clk;

  task automatic push_range(input logic [2:0] ph, input logic [7:0] lane, input int from, input int to);
    exp_t e;
    for (int k = from; k >= to; k--) begin
      e.ph   = ph;
      e.lane = lane;
      e.tm   = 7'(k);
      e.wk   = (ph == 3'd6);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (phase !== e.ph) begin
        errors++;
        $display("FAIL %s[%0d] phase got %0d want %0d", tag, n, phase, e.ph);
      end
      checks++;
      if (lane_output !== e.lane) begin
        errors++;
        $display("FAIL %s[%0d] lane_output got %b want %b", tag, n, lane_output, e.lane);
      end
      checks++;
      if (timer !== e.tm) begin
        errors++;
        $display("FAIL %s[%0d] timer got %0d want %0d", tag, n, timer, e.tm);
      end
`ifdef PED_WALK_EN
      checks++;
      if (walk !== e.wk) begin
        errors++;
        $display("FAIL %s[%0d] walk got %0d want %0d", tag, n, walk, e.wk);
      end
`endif
      n++;
    end
    $display("%s: %0d cycles checked", tag, n);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL %s phase got %0d want 0", tag, phase);
    end
    checks++;
    if (lane_output !== L_RED) begin
      errors++;
      $display("FAIL %s lane_output got %b want %b", tag, lane_output, L_RED);
    end
    checks++;
    if (timer !== 7'd1) begin
      errors++;
      $display("FAIL %s timer got %0d want 1", tag, timer);
    end
`ifdef PED_WALK_EN
    checks++;
    if (walk !== 1'b0) begin
      errors++;
      $display("FAIL %s walk got %0d want 0", tag, walk);
    end
`endif
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    night_mode = 1'b0;
    load_time  = 7'd5;
    ns_request = 1'b0;
    ew_request = 1'b0;
`ifdef PED_WALK_EN
    ped_request = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    $display("reset: reset values checked");
  endtask

  task automatic test_day();
    rst = 1'b0;
    push_range(3'd0, L_RED, 0, 0);
    push_range(3'd1, L_NSG, 4, 0);
    push_range(3'd2, L_NSY, 3, 0);
    push_range(3'd3, L_RED, 1, 0);
    push_range(3'd4, L_EWG, 4, 0);
    push_range(3'd5, L_EWY, 3, 0);
    push_range(3'd0, L_RED, 1, 0);
    push_range(3'd1, L_NSG, 4, 0);
    drain("day_cycle");
  endtask

  task automatic test_load_zero();
    load_time = 7'd0;
    push_range(3'd2, L_NSY, 3, 0);
    push_range(3'd3, L_RED, 1, 0);
    push_range(3'd4, L_EWG, 0, 0);
    push_range(3'd5, L_EWY, 3, 0);
    push_range(3'd0, L_RED, 1, 0);
    push_range(3'd1, L_NSG, 0, 0);
    push_range(3'd2, L_NSY, 3, 3);
    drain("load_zero");
  endtask

  task automatic test_night_toggle();
    night_mode = 1'b1;
    load_time  = 7'd3;
    push_range(3'd2, L_NSY, 2, 0);
    push_range(3'd3, L_RED, 1, 0);
    push_range(3'd4, L_EWG, 2, 0);
    for (int i = 0; i < 6; i++) push_range(3'd4, L_EWG, 0, 0);
    drain("night_toggle_hold_ew");
    ns_request = 1'b1;
    push_range(3'd5, L_EWY, 3, 0);
    push_range(3'd0, L_RED, 1, 0);
    push_range(3'd1, L_NSG, 2, 0);
    for (int i = 0; i < 6; i++) push_range(3'd1, L_NSG, 0, 0);
    drain("night_hold_ns");
  endtask

  task automatic test_back_to_back();
    ew_request = 1'b1;
    push_range(3'd2, L_NSY, 3, 0);
    push_range(3'd3, L_RED, 1, 0);
    push_range(3'd4, L_EWG, 2, 2);
    drain("night_release");
    load_time = 7'd7;
    push_range(3'd4, L_EWG, 1, 0);
    push_range(3'd5, L_EWY, 3, 0);
    push_range(3'd0, L_RED, 1, 0);
    push_range(3'd1, L_NSG, 6, 0);
    push_range(3'd2, L_NSY, 3, 3);
    drain("both_requests_load_change");
    night_mode = 1'b0;
    ns_request = 1'b0;
    ew_request = 1'b0;
  endtask

  task automatic test_reset_mid();
    push_range(3'd2, L_NSY, 2, 0);
    push_range(3'd3, L_RED, 1, 0);
    push_range(3'd4, L_EWG, 6, 4);
    drain("to_ew_green");
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset_mid_ew");
    @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b0;
    push_range(3'd0, L_RED, 0, 0);
    push_range(3'd1, L_NSG, 6, 3);
    drain("after_mid_reset");
  endtask

  task automatic test_ped();
`ifdef PED_WALK_EN
    ped_request = 1'b1;
    push_range(3'd1, L_NSG, 2, 2);
    drain("ped_pulse");
    ped_request = 1'b0;
    push_range(3'd1, L_NSG, 1, 0);
    push_range(3'd2, L_NSY, 3, 0);
    push_range(3'd6, L_RED, 9, 0);
    push_range(3'd4, L_EWG, 6, 0);
    push_range(3'd5, L_EWY, 3, 0);
    push_range(3'd0, L_RED, 1, 0);
    push_range(3'd1, L_NSG, 6, 0);
    push_range(3'd2, L_NSY, 3, 0);
    push_range(3'd3, L_RED, 1, 0);
    drain("ped_walk");
`else
    push_range(3'd1, L_NSG, 2, 0);
    push_range(3'd2, L_NSY, 3, 0);
    push_range(3'd3, L_RED, 1, 0);
    push_range(3'd4, L_EWG, 6, 0);
    drain("no_walk_phase");
`endif
  endtask

  initial begin
    test_reset();
    test_day();
    test_load_zero();
    test_night_toggle();
    test_back_to_back();
    test_reset_mid();
    test_ped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
